dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Data-memory stage directly downstream of the single-cycle datapath. It takes the ALU address and the register write data, and returns the read data consumed by the write-back mux. It bridges the one-cycle datapath access to a variable-latency memory bus with valid/ready handshakes. When an access cannot complete in one cycle it asserts a stall that freezes the PC and register-file write. A one-entry posted store buffer lets most stores retire without stalling.

Parameters:
WORD_W, 32, data and address width.
FWD_EN, 1, when 1, a load whose word address matches the buffered store returns the buffered data without a bus access.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
reset_i  in  1  asynchronous, active-high reset.
mem_read_i  in  1  current instruction is a load.
mem_write_i  in  1  current instruction is a store.
addr_i32  in  32  byte address from the ALU output.
wdata_i32  in  32  store data from register-file read port 2.
rdata_o32  out  32  load data to the write-back mux; valid when mem_read_i=1 and stall_o=0.
stall_o  out  1  combinational; 1 means hold PC and suppress register writes this cycle.
misalign_o  out  1  combinational; addr_i32[1:0]!=0 with mem_read_i or mem_write_i asserted.
bus_req_valid_o  out  1  bus request valid.
bus_req_ready_i  in  1  bus accepts the request; a handshake is valid & ready.
bus_req_we_o  out  1  1 = write request, 0 = read request.
bus_req_addr_o32  out  32  word-aligned address; bits [1:0] are always 0.
bus_req_wdata_o32  out  32  write data.
bus_resp_valid_i  in  1  read response valid, one cycle.
bus_resp_rdata_i32  in  32  read response data.

Behaviour:
- Reset (asynchronous, active-high), applied immediately:
  - FSM goes to IDLE.
  - Store buffer is emptied: sb_valid=0, sb_addr=0, sb_data=0.
  - Load register cleared to 0.
  - All bus outputs are 0; rdata_o32=0.
  - stall_o follows its equation with FSM=IDLE and sb_valid=0.
- Reset mid-transaction: any outstanding read is abandoned. A bus_resp_valid_i arriving while not in LD_WAIT is ignored.
- Word address = {addr_i32[31:2], 2'b00}.
- A misaligned access still proceeds using the word address; misalign_o is informational only.
- mem_read_i and mem_write_i both high: the read wins and the write is dropped.
- Store buffer drain:
  - When sb_valid=1, the block drives bus_req_valid_o=1, we=1, addr=sb_addr, wdata=sb_data.
  - Request fields are held stable until the handshake.
  - Writes complete on the handshake and have no response.
  - Drain has bus priority over loads.
- Store path:
  - Captured in the buffer at the clock edge when mem_write_i=1 and (sb_valid=0 or a drain handshake occurs this cycle).
  - stall_o = mem_write_i & sb_valid & ~(bus_req_valid_o & bus_req_ready_i & bus_req_we_o).
  - A back-to-back store therefore retires in the cycle its predecessor drains.
- Load path, FSM IDLE -> LD_REQ -> LD_WAIT -> LD_DONE -> IDLE:
  - IDLE, load hit (FWD_EN=1, sb_valid=1, word addresses equal): rdata_o32=sb_data, stall_o=0, no bus access.
  - IDLE, load miss: stall_o=1. If sb_valid=1, stay in IDLE until the buffer has drained. Once sb_valid=0, move to LD_REQ on the next edge.
  - LD_REQ: bus_req_valid_o=1, we=0, addr=word address; stall_o=1. Go to LD_WAIT on the handshake.
  - LD_WAIT: stall_o=1. On bus_resp_valid_i, capture bus_resp_rdata_i32 into the load register and go to LD_DONE.
  - LD_DONE: stall_o=0, rdata_o32 = load register; the instruction retires. Go to IDLE unconditionally.
  - Minimum load-miss latency with zero-wait bus (ready=1, response the cycle after the handshake): 3 stalled cycles, then the LD_DONE retire cycle.
  - No new store is captured while the FSM is outside IDLE (stall_o=1 freezes the instruction).
- rdata_o32 outside load cycles: holds the load register value.

Decomposition:
- dmem_pkg:
  - state typedef enum {IDLE, LD_REQ, LD_WAIT, LD_DONE};
  - WORD_W constant;
  - word-align function.
- Sub-module store_buf:
  - one-entry buffer: valid/addr/data registers, capture and drain-handshake logic, address-match output;
  - instantiated once in dmem_ctrl.

Test Plan:
- Store then load hit: sw 0xDEADBEEF @0x40 with ready=0, then lw @0x40 -> stall_o=0 both cycles, rdata_o32=0xDEADBEEF, no read request issued.
- Load miss, zero-wait bus: lw @0x100, ready=1, response 0x12345678 one cycle after the handshake -> stall_o=1 for 3 cycles, then stall_o=0 with rdata_o32=0x12345678.
- Back-to-back stores: sw @0x0 then sw @0x4, ready low for 2 cycles -> second store stalls 2 cycles and is captured on the drain handshake cycle; bus sees write 0x0 then write 0x4.
- Load behind a pending store to a different address: sb holds @0x8, lw @0xC -> write @0x8 completes before the read @0xC is issued; stall continues through the read.
- Reset during LD_WAIT: assert reset_i asynchronously -> bus_req_valid_o=0 immediately, stall_o=0; a later bus_resp_valid_i is ignored and rdata_o32 stays 0.
- Misaligned and dual-assert access: lw @0x43 -> misalign_o=1, bus address 0x40; mem_read_i=mem_write_i=1 -> only a read is issued and the store buffer is unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the data-memory stage
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        LD_DONE
    } state_t;

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
        return a & ~WORD_W'(3);
    endfunction

endpackage

// File: rtl/store_buf.sv
// rtl/store_buf.sv - one-entry posted store buffer with drain handshake and load address match
module store_buf #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              drain_done,
    input  logic [WORD_W-1:0] cap_addr,
    input  logic [WORD_W-1:0] cap_data,
    input  logic [WORD_W-1:0] cmp_addr,
    output logic              valid,
    output logic [WORD_W-1:0] addr,
    output logic [WORD_W-1:0] data,
    output logic              match
);
    import dmem_pkg::*;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (capture) begin
            valid <= 1'b1;
            addr  <= cap_addr;
            data  <= cap_data;
        end else if (drain_done) begin
            valid <= 1'b0;
        end
    end

    assign match = valid && (addr == word_align(cmp_addr));

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory stage bridging the single-cycle datapath to a valid/ready memory bus
module dmem_ctrl #(
    parameter int WORD_W = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [WORD_W-1:0] addr_i32,
    input  logic [WORD_W-1:0] wdata_i32,
    output logic [WORD_W-1:0] rdata_o32,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              bus_req_valid_o,
    input  logic              bus_req_ready_i,
    output logic              bus_req_we_o,
    output logic [WORD_W-1:0] bus_req_addr_o32,
    output logic [WORD_W-1:0] bus_req_wdata_o32,
    input  logic              bus_resp_valid_i,
    input  logic [WORD_W-1:0] bus_resp_rdata_i32
);
    import dmem_pkg::*;

    state_t            state, state_nx;
    logic [WORD_W-1:0] word_addr;
    logic [WORD_W-1:0] load_q;
    logic [WORD_W-1:0] sb_addr, sb_data;
    logic              sb_valid, sb_match;
    logic              drain_hs, load_hit, sb_capture;

    assign word_addr  = word_align(addr_i32);
    assign drain_hs   = sb_valid & bus_req_ready_i;
    assign load_hit   = FWD_EN && sb_match;
    // A store that arrives together with a load is dropped: the read wins.
    assign sb_capture = mem_write_i & ~mem_read_i & (state == IDLE) & (~sb_valid | drain_hs);
    assign misalign_o = (mem_read_i | mem_write_i) & (addr_i32[1:0] != 2'b00);

    store_buf #(.WORD_W(WORD_W)) u_store_buf (
        .clk        (clk_i),
        .rst        (reset_i),
        .capture    (sb_capture),
        .drain_done (drain_hs),
        .cap_addr   (word_addr),
        .cap_data   (wdata_i32),
        .cmp_addr   (addr_i32),
        .valid      (sb_valid),
        .addr       (sb_addr),
        .data       (sb_data),
        .match      (sb_match)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state  <= IDLE;
            load_q <= '0;
        end else begin
            state <= state_nx;
            if (state == LD_WAIT && bus_resp_valid_i) begin
                load_q <= bus_resp_rdata_i32;
            end
        end
    end

    always_comb begin
        state_nx          = state;
        stall_o           = 1'b0;
        rdata_o32         = load_q;
        bus_req_valid_o   = 1'b0;
        bus_req_we_o      = 1'b0;
        bus_req_addr_o32  = '0;
        bus_req_wdata_o32 = '0;

        // The draining store always owns the bus; a read is only issued once it is empty.
        if (sb_valid) begin
            bus_req_valid_o   = 1'b1;
            bus_req_we_o      = 1'b1;
            bus_req_addr_o32  = sb_addr;
            bus_req_wdata_o32 = sb_data;
        end else if (state == LD_REQ) begin
            bus_req_valid_o   = 1'b1;
            bus_req_addr_o32  = word_addr;
        end

        case (state)
            IDLE: begin
                if (mem_read_i) begin
                    if (load_hit) begin
                        rdata_o32 = sb_data;
                    end else begin
                        stall_o = 1'b1;
                        if (!sb_valid) begin
                            state_nx = LD_REQ;
                        end
                    end
                end else if (mem_write_i) begin
                    stall_o = sb_valid & ~drain_hs;
                end
            end
            LD_REQ: begin
                stall_o = 1'b1;
                if (bus_req_ready_i && !sb_valid) begin
                    state_nx = LD_WAIT;
                end
            end
            LD_WAIT: begin
                stall_o = 1'b1;
                if (bus_resp_valid_i) begin
                    state_nx = LD_DONE;
                end
            end
            LD_DONE: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl with a bus-transaction scoreboard
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        mem_read_i, mem_write_i;
    logic [31:0] addr_i32, wdata_i32, rdata_o32;
    logic        stall_o, misalign_o;
    logic        bus_req_valid_o, bus_req_ready_i, bus_req_we_o;
    logic [31:0] bus_req_addr_o32, bus_req_wdata_o32;
    logic        bus_resp_valid_i;
    logic [31:0] bus_resp_rdata_i32;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    bus_t        exp_q[$];
    bus_t        mon_e;
    int          total = 0;
    int          bad = 0;
    logic [31:0] resp_word;

    always #5 clk = ~clk;

    dmem_ctrl #(.WORD_W(32), .FWD_EN(1'b1)) dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .mem_read_i         (mem_read_i),
        .mem_write_i        (mem_write_i),
        .addr_i32           (addr_i32),
        .wdata_i32          (wdata_i32),
        .rdata_o32          (rdata_o32),
        .stall_o            (stall_o),
        .misalign_o         (misalign_o),
        .bus_req_valid_o    (bus_req_valid_o),
        .bus_req_ready_i    (bus_req_ready_i),
        .bus_req_we_o       (bus_req_we_o),
        .bus_req_addr_o32   (bus_req_addr_o32),
        .bus_req_wdata_o32  (bus_req_wdata_o32),
        .bus_resp_valid_i   (bus_resp_valid_i),
        .bus_resp_rdata_i32 (bus_resp_rdata_i32)
    );

    function automatic bus_t mk(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus_t t;
        t.we = we;
        t.addr = a;
        t.wdata = d;
        return t;
    endfunction

    always @(negedge clk) begin
        if (!reset_i && bus_req_valid_o && bus_req_ready_i) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL bus_unexpected got we=%0b addr=%h required=no transfer", bus_req_we_o, bus_req_addr_o32);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus_req_we_o !== mon_e.we || bus_req_addr_o32 !== mon_e.addr ||
                    (mon_e.we && bus_req_wdata_o32 !== mon_e.wdata)) begin
                    bad++;
                    $display("FAIL bus_xfer got we=%0b addr=%h wdata=%h required we=%0b addr=%h wdata=%h",
                             bus_req_we_o, bus_req_addr_o32, bus_req_wdata_o32, mon_e.we, mon_e.addr, mon_e.wdata);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        addr_i32    = '0;
        wdata_i32   = '0;
    endtask

    // Counts stalled cycles of the current instruction, answering each read handshake one cycle later.
    task automatic run_load(input int max, output int stalls);
        logic pend;
        stalls = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (stall_o !== 1'b1) break;
            stalls++;
            pend = bus_req_valid_o & bus_req_ready_i & ~bus_req_we_o;
            tick();
            bus_resp_valid_i   = pend;
            bus_resp_rdata_i32 = resp_word;
        end
        bus_resp_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        clear_in();
        bus_req_ready_i    = 1'b0;
        bus_resp_valid_i   = 1'b0;
        bus_resp_rdata_i32 = '0;
        tick();
        @(negedge clk);
        total++;
        if ({bus_req_valid_o, bus_req_we_o, bus_req_addr_o32, bus_req_wdata_o32} !== 66'd0) begin
            bad++;
            $display("FAIL reset_bus got %0b/%0b/%h/%h required all zero", bus_req_valid_o, bus_req_we_o, bus_req_addr_o32, bus_req_wdata_o32);
        end
        total++;
        if (rdata_o32 !== 32'd0) begin bad++; $display("FAIL reset_rdata got %h required 0", rdata_o32); end
        tick();
        reset_i = 1'b0;
        @(negedge clk);
        total++;
        if ({stall_o, misalign_o, bus_req_valid_o} !== 3'b000) begin
            bad++;
            $display("FAIL reset_idle got stall/mis/valid=%b required 000", {stall_o, misalign_o, bus_req_valid_o});
        end
    endtask

    task automatic test_store_hit;
        tick();
        bus_req_ready_i = 1'b0;
        mem_write_i = 1'b1; addr_i32 = 32'h40; wdata_i32 = 32'hDEADBEEF;
        exp_q.push_back(mk(1'b1, 32'h40, 32'hDEADBEEF));
        @(negedge clk);
        total++;
        if (stall_o !== 1'b0) begin bad++; $display("FAIL hit_store_stall got %b required 0", stall_o); end
        tick();
        clear_in();
        mem_read_i = 1'b1; addr_i32 = 32'h40;
        @(negedge clk);
        total++;
        if (stall_o !== 1'b0) begin bad++; $display("FAIL hit_load_stall got %b required 0", stall_o); end
        total++;
        if (rdata_o32 !== 32'hDEADBEEF) begin bad++; $display("FAIL hit_rdata got %h required deadbeef", rdata_o32); end
        total++;
        if ({bus_req_valid_o, bus_req_we_o} !== 2'b11) begin
            bad++;
            $display("FAIL hit_no_read got valid/we=%b required 11", {bus_req_valid_o, bus_req_we_o});
        end
        tick();
        clear_in();
        bus_req_ready_i = 1'b1;
        tick();
        bus_req_ready_i = 1'b0;
        @(negedge clk);
        total++;
        if (bus_req_valid_o !== 1'b0) begin bad++; $display("FAIL hit_drained got %b required 0", bus_req_valid_o); end
    endtask

    task automatic test_load_miss;
        int n;
        tick();
        bus_req_ready_i = 1'b1;
        resp_word = 32'h12345678;
        mem_read_i = 1'b1; addr_i32 = 32'h100;
        exp_q.push_back(mk(1'b0, 32'h100, 32'h0));
        run_load(20, n);
        total++;
        if (n != 3) begin bad++; $display("FAIL miss_stalls got %0d required 3", n); end
        total++;
        if (rdata_o32 !== 32'h12345678) begin bad++; $display("FAIL miss_rdata got %h required 12345678", rdata_o32); end
        tick();
        clear_in();
        @(negedge clk);
        total++;
        if ({stall_o, rdata_o32} !== {1'b0, 32'h12345678}) begin
            bad++;
            $display("FAIL miss_hold got stall=%b rdata=%h required 0/12345678", stall_o, rdata_o32);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        tick();
        bus_req_ready_i = 1'b0;
        mem_write_i = 1'b1; addr_i32 = 32'h0; wdata_i32 = 32'hA0A0A0A0;
        exp_q.push_back(mk(1'b1, 32'h0, 32'hA0A0A0A0));
        @(negedge clk);
        total++;
        if (stall_o !== 1'b0) begin bad++; $display("FAIL b2b_first_stall got %b required 0", stall_o); end
        tick();
        addr_i32 = 32'h4; wdata_i32 = 32'hB1B1B1B1;
        n = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (stall_o === 1'b1) n++;
            tick();
        end
        total++;
        if (n != 2) begin bad++; $display("FAIL b2b_stalls got %0d required 2", n); end
        bus_req_ready_i = 1'b1;
        exp_q.push_back(mk(1'b1, 32'h4, 32'hB1B1B1B1));
        @(negedge clk);
        total++;
        if (stall_o !== 1'b0) begin bad++; $display("FAIL b2b_retire got %b required 0", stall_o); end
        tick();
        clear_in();
        @(negedge clk);
        total++;
        if ({bus_req_valid_o, bus_req_we_o, bus_req_addr_o32} !== {2'b11, 32'h4}) begin
            bad++;
            $display("FAIL b2b_second got %b/%b/%h required 1/1/00000004", bus_req_valid_o, bus_req_we_o, bus_req_addr_o32);
        end
        tick();
        bus_req_ready_i = 1'b0;
    endtask

    task automatic test_load_behind_store;
        int n;
        bus_req_ready_i = 1'b0;
        mem_write_i = 1'b1; addr_i32 = 32'h8; wdata_i32 = 32'h00008888;
        exp_q.push_back(mk(1'b1, 32'h8, 32'h00008888));
        tick();
        clear_in();
        mem_read_i = 1'b1; addr_i32 = 32'hC;
        resp_word = 32'hCCCC0000;
        exp_q.push_back(mk(1'b0, 32'hC, 32'h0));
        @(negedge clk);
        total++;
        if ({stall_o, bus_req_valid_o, bus_req_we_o, bus_req_addr_o32} !== {3'b111, 32'h8}) begin
            bad++;
            $display("FAIL lbs_pending got stall=%b valid=%b we=%b addr=%h required 1/1/1/00000008",
                     stall_o, bus_req_valid_o, bus_req_we_o, bus_req_addr_o32);
        end
        tick();
        bus_req_ready_i = 1'b1;
        run_load(20, n);
        total++;
        if (n != 4) begin bad++; $display("FAIL lbs_stalls got %0d required 4", n); end
        total++;
        if (rdata_o32 !== 32'hCCCC0000) begin bad++; $display("FAIL lbs_rdata got %h required cccc0000", rdata_o32); end
        tick();
        clear_in();
    endtask

    task automatic test_reset_mid;
        bus_req_ready_i = 1'b1;
        mem_read_i = 1'b1; addr_i32 = 32'h200;
        exp_q.push_back(mk(1'b0, 32'h200, 32'h0));
        tick();
        tick();
        @(negedge clk);
        total++;
        if ({stall_o, bus_req_valid_o} !== 2'b10) begin
            bad++;
            $display("FAIL rst_wait got stall/valid=%b required 10", {stall_o, bus_req_valid_o});
        end
        #1;
        reset_i = 1'b1;
        clear_in();
        #1;
        total++;
        if ({stall_o, bus_req_valid_o, rdata_o32} !== 34'd0) begin
            bad++;
            $display("FAIL rst_async got stall=%b valid=%b rdata=%h required 0/0/0", stall_o, bus_req_valid_o, rdata_o32);
        end
        tick();
        reset_i = 1'b0;
        bus_resp_valid_i = 1'b1; bus_resp_rdata_i32 = 32'hBADBAD00;
        tick();
        bus_resp_valid_i = 1'b0;
        @(negedge clk);
        total++;
        if ({stall_o, bus_req_valid_o, rdata_o32} !== 34'd0) begin
            bad++;
            $display("FAIL rst_stray_resp got stall=%b valid=%b rdata=%h required 0/0/0", stall_o, bus_req_valid_o, rdata_o32);
        end
    endtask

    task automatic test_misalign_dual;
        int n;
        tick();
        bus_req_ready_i = 1'b1;
        mem_read_i = 1'b1; addr_i32 = 32'h43;
        resp_word = 32'h43434343;
        exp_q.push_back(mk(1'b0, 32'h40, 32'h0));
        #1;
        total++;
        if (misalign_o !== 1'b1) begin bad++; $display("FAIL mis_load got %b required 1", misalign_o); end
        run_load(20, n);
        total++;
        if ({n[7:0], rdata_o32} !== {8'd3, 32'h43434343}) begin
            bad++;
            $display("FAIL mis_load_done got stalls=%0d rdata=%h required 3/43434343", n, rdata_o32);
        end
        tick();
        mem_read_i = 1'b1; mem_write_i = 1'b1; addr_i32 = 32'h80; wdata_i32 = 32'h00005555;
        resp_word = 32'h80808080;
        exp_q.push_back(mk(1'b0, 32'h80, 32'h0));
        #1;
        total++;
        if (misalign_o !== 1'b0) begin bad++; $display("FAIL dual_misalign got %b required 0", misalign_o); end
        run_load(20, n);
        total++;
        if ({n[7:0], rdata_o32} !== {8'd3, 32'h80808080}) begin
            bad++;
            $display("FAIL dual_load got stalls=%0d rdata=%h required 3/80808080", n, rdata_o32);
        end
        tick();
        clear_in();
        @(negedge clk);
        total++;
        if (bus_req_valid_o !== 1'b0) begin bad++; $display("FAIL dual_no_store got %b required 0", bus_req_valid_o); end
        tick();
        mem_write_i = 1'b1; addr_i32 = 32'h42; wdata_i32 = 32'h42424242;
        exp_q.push_back(mk(1'b1, 32'h40, 32'h42424242));
        #1;
        total++;
        if (misalign_o !== 1'b1) begin bad++; $display("FAIL mis_store got %b required 1", misalign_o); end
        tick();
        clear_in();
        tick();
        tick();
    endtask

    initial begin
        reset_i = 1'b1;
        test_reset();
        test_store_hit();
        test_load_miss();
        test_back_to_back();
        test_load_behind_store();
        test_reset_mid();
        test_misalign_dual();
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
